// File: rtl/adc_cap_pkg.sv
// Shared definitions for the ADC capture path: readout state encoding,
// default drain depth and word-counter width derivation.
`default_nettype none

package adc_cap_pkg;

  localparam int NWORDS_DEFAULT = 65536;

  // The counter must be able to hold NWORDS itself, not just NWORDS-1.
  function automatic int cw_for(input int nwords);
    return $clog2(nwords + 1);
  endfunction

  localparam int CW_DEFAULT = cw_for(NWORDS_DEFAULT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_LO    = 3'd3,
    ST_HI    = 3'd4,
    ST_DONE  = 3'd5
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_readout_ctrl.sv
// Drains NWORDS 16-bit words from the capture FIFO read port and streams
// them as bytes (low byte first) over a valid/ready handshake.
`default_nettype none

module fifo_readout_ctrl
  import adc_cap_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEFAULT,
  parameter int CW     = cw_for(NWORDS)
) (
  input  logic          rdclk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [15:0]   data_out,
  output logic          rden,
  output logic [7:0]    byte_out,
  output logic          byte_valid,
  input  logic          byte_ready,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] words_left
);

  localparam logic [CW-1:0] NWORDS_W = CW'(NWORDS);

  rd_state_e     state_q, state_d;
  logic [CW-1:0] words_left_q, words_left_d;
  logic [15:0]   word_q, word_d;

  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      word_q       <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      word_q       <= word_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    word_d       = word_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_FETCH;
          words_left_d = NWORDS_W;
        end
      end
      ST_FETCH: begin
        words_left_d = words_left_q - CW'(1);
        state_d      = ST_LOAD;
      end
      ST_LOAD: begin
        word_d  = data_out;
        state_d = ST_LO;
      end
      ST_LO: begin
        if (byte_ready) state_d = ST_HI;
      end
      ST_HI: begin
        if (byte_ready) state_d = (words_left_q != '0) ? ST_FETCH : ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any handshake; DONE already leads straight back to IDLE.
    if (abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) state_d = ST_DONE;
  end

  // Every output decodes registered state only, so byte_ready never reaches them combinationally.
  assign rden       = (state_q == ST_FETCH);
  assign byte_valid = (state_q == ST_LO) || (state_q == ST_HI);
  assign byte_out   = (state_q == ST_LO) ? word_q[7:0]
                    : (state_q == ST_HI) ? word_q[15:8]
                    : 8'h00;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign words_left = words_left_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_readout_ctrl.sv
// Bench for fifo_readout_ctrl: event-rule reference model with a byte
// scoreboard, plus literal timeline checks and a full-depth counter probe.
`default_nettype none

module tb_fifo_readout_ctrl;

  localparam int N   = 4;
  localparam int CWS = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           byte_ready = 1'b0;
  logic [15:0]    data_out = '0;
  logic           rden, byte_valid, busy, done;
  logic [7:0]     byte_out;
  logic [CWS-1:0] words_left;

  logic           big_start = 1'b0;
  logic           big_abort = 1'b0;
  logic           big_ready = 1'b1;
  logic [15:0]    big_data = 16'h5AA5;
  logic           big_rden, big_valid, big_busy, big_done;
  logic [7:0]     big_byte;
  logic [16:0]    big_wl;

  fifo_readout_ctrl #(.NWORDS(N), .CW(CWS)) u_dut (
    .rdclk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .data_out(data_out), .rden(rden), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy),
    .done(done), .words_left(words_left)
  );

  fifo_readout_ctrl #(.NWORDS(65536), .CW(17)) u_big (
    .rdclk(clk), .rst_n(rst_n), .start(big_start), .abort(big_abort),
    .data_out(big_data), .rden(big_rden), .byte_out(big_byte),
    .byte_valid(big_valid), .byte_ready(big_ready), .busy(big_busy),
    .done(big_done), .words_left(big_wl)
  );

  always #5 clk = ~clk;

  // FIFO read port model: data appears one clock after rden.
  logic [15:0] mem [0:4095];
  int          rd_ptr = 0;
  always @(posedge clk) begin
    if (rden) begin
      data_out <= mem[rd_ptr % 4096];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected outputs for the coming cycle, derived from the
  // readout rules (fetch count, accepted-byte count, expected byte stream).
  bit         e_busy, e_rden, e_valid, e_done, e_load;
  int         m_fetched, m_acc, m_widx;
  logic [7:0] m_q[$];
  logic [7:0] got[$];
  int         rden_cnt;

  initial begin
    e_busy = 0; e_rden = 0; e_valid = 0; e_done = 0; e_load = 0;
    m_fetched = 0; m_acc = 0; m_widx = 0; rden_cnt = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rden", rden, 0);
      check("rst_byte_valid", byte_valid, 0);
      check("rst_byte_out", byte_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_words_left", words_left, 0);
      e_busy = 0; e_rden = 0; e_valid = 0; e_done = 0; e_load = 0;
      m_fetched = 0; m_acc = 0;
      m_q.delete();
    end else begin
      bit abort_eff, start_acc, acc, hi_acc;
      bit n_rden, n_load, n_valid, n_done, n_busy;
      check("busy", busy, e_busy);
      check("rden", rden, e_rden);
      check("byte_valid", byte_valid, e_valid);
      check("done", done, e_done);
      if (e_valid) begin
        if (m_q.size() == 0) check("stream_underrun", 1, 0);
        else                 check("byte_out", byte_out, m_q[0]);
      end
      if (e_busy) check("words_left", words_left, N - m_fetched);
      if (byte_valid && byte_ready && !abort) got.push_back(byte_out);
      if (rden) rden_cnt++;

      abort_eff = abort && e_busy && !e_done;
      start_acc = start && !e_busy;
      if (e_rden) begin
        m_q.push_back(mem[m_widx % 4096][7:0]);
        m_q.push_back(mem[m_widx % 4096][15:8]);
        m_widx++;
        m_fetched++;
      end
      acc    = e_valid && byte_ready && !abort_eff;
      hi_acc = acc && (m_acc % 2 == 1);
      if (acc) begin
        void'(m_q.pop_front());
        m_acc++;
      end
      n_rden  = !abort_eff && (start_acc || (hi_acc && m_fetched < N));
      n_load  = e_rden && !abort_eff;
      n_valid = !abort_eff && (e_load || (e_valid && !hi_acc));
      n_done  = e_busy && !e_done && (abort_eff || (hi_acc && m_fetched == N));
      n_busy  = e_busy ? !e_done : start_acc;
      if (abort_eff) m_q.delete();
      if (start_acc) begin
        m_fetched = 0;
        m_acc     = 0;
        m_q.delete();
      end
      e_rden = n_rden; e_load = n_load; e_valid = n_valid;
      e_done = n_done; e_busy = n_busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp1 [8];
    int done_cyc;
    bit seen;
    exp1 = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'hFF, 8'hFF};
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0001; mem[3] = 16'hFFFF;

    repeat (3) @(posedge clk);
    #1;
    check("rst_big_wl", big_wl, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    check("idle_busy", busy, 0);
    check("idle_rden", rden, 0);

    // Full-depth instance: counter loads 65536 without truncation, then counts down.
    big_start = 1'b1; tick(); big_start = 1'b0;
    check("big_rden_c1", big_rden, 1);
    check("big_wl_c1", big_wl, 17'h10000);
    tick();
    check("big_wl_c2", big_wl, 65535);
    repeat (3) tick();
    check("big_rden_c5", big_rden, 1);
    check("big_wl_c5", big_wl, 65535);
    tick();
    check("big_wl_c6", big_wl, 65534);

    // Full-rate drain of the four known words.
    got.delete(); rden_cnt = 0;
    byte_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    done_cyc = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (done) done_cyc = c;
      else tick();
    end
    check("t1_done_cycle", done_cyc, 17);
    check("t1_rden_pulses", rden_cnt, 4);
    check("t1_nbytes", got.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t1_byte%0d", i), (i < got.size()) ? got[i] : 8'hxx, exp1[i]);
    tick();
    check("t1_busy_fall", busy, 0);
    repeat (2) tick();

    // Start while busy, then asynchronous reset while a low byte is offered.
    byte_ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    check("sb_valid_lo", byte_valid, 1);
    rst_n = 1'b0;
    #1;
    check("ar_valid", byte_valid, 0);
    check("ar_busy", busy, 0);
    check("ar_words_left", words_left, 0);
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    check("rs_rden", rden, 1);
    check("rs_words_left", words_left, N);
    byte_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (done) seen = 1;
      else tick();
    end
    check("rs_done_seen", seen, 1);
    repeat (2) tick();

    // Abort while the high byte of word 3 is offered.
    got.delete(); rden_cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (11) tick();
    check("ab_valid_hi", byte_valid, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("ab_done", done, 1);
    check("ab_rden_pulses", rden_cnt, 3);
    check("ab_nbytes", got.size(), 5);
    repeat (4) begin
      tick();
      check("ab_no_valid", byte_valid, 0);
    end

    // Randomised backpressure with stray starts and occasional aborts.
    for (int r = 0; r < 15; r++) begin
      byte_ready = 1'($urandom % 2);
      start = 1'b1; tick(); start = 1'b0;
      seen = 0;
      for (int c = 0; c < 300 && !seen; c++) begin
        if (done) seen = 1;
        else begin
          byte_ready = ($urandom % 3) != 0;
          start      = ($urandom % 8) == 0;
          abort      = ($urandom % 80) == 0;
          tick();
        end
      end
      start = 1'b0; abort = 1'b0;
      check("rand_done_seen", seen, 1);
      repeat (1 + $urandom % 2) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
